uart_rx_frame_checker: RTL and testbench
========================================

Name: uart_rx_frame_checker

Overview:
Parametrised UART receive-frame engine that supersedes the fixed even-parity checker. It runs on the synchronised serial line and a baud oversample tick, and performs start detection, mid-bit sampling, data assembly, parity checking, stop-bit checking and break detection. Parity mode is runtime-selectable: none, even, odd, mark or space. It sits between the input synchroniser/baud generator and the RX FIFO, and supplies per-frame status plus a saturating parity-error counter.

Parameters:
INPUT_DATA_WIDTH, 8, data bits per frame; legal range 5..9; sent LSB first.
OVERSAMPLE, 16, baud_tick pulses per bit period; even number, >= 4.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.
ERR_CNT_WIDTH, 8, width of the saturating parity-error counter.

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-low reset.
serial_in_synced  input  1  RX line, already synchronised to clk; idle high.
baud_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate.
parity_mode  input  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101..111 treated as none.
clear_counts  input  1  synchronous clear of parity_err_count.
received_data  output  INPUT_DATA_WIDTH  last completed frame's data.
data_valid  output  1  one-clk pulse when a non-break frame completes.
parity_error  output  1  parity status of last frame; held until next frame completes.
framing_error  output  1  stop-bit status of last frame; held until next frame completes.
break_detected  output  1  one-clk pulse on break condition.
is_parity_stage  output  1  high while in PARITY state.
parity_err_count  output  ERR_CNT_WIDTH  saturating count of parity-error frames.

Behaviour:
- Reset low (asynchronous): state=IDLE, tick_cnt=0, bit_idx=0, shift register=0, all outputs 0 including parity_err_count. Reset mid-frame aborts the frame; no data_valid is produced for it.
- All sampling happens only in cycles where baud_tick=1. tick_cnt counts baud_ticks within the current bit.
- IDLE: on baud_tick with line=0, latch parity_mode into mode_q, tick_cnt=0, go to START. mode_q is fixed for the whole frame; parity_mode changes mid-frame have no effect on that frame.
- START: at tick_cnt=OVERSAMPLE/2-1, sample the line.
  - Line=1: glitch; return to IDLE with no output.
  - Line=0: tick_cnt=0, bit_idx=0, go to DATA.
- DATA: sample at tick_cnt=OVERSAMPLE-1, which is the mid-bit point from here on. Shift the sample in at the MSB so the first bit ends at the LSB; increment bit_idx.
  - After INPUT_DATA_WIDTH bits: go to PARITY if mode_q is even/odd/mark/space, otherwise go to STOP.
- PARITY: sample one bit.
  - Expected value: even = ^data; odd = ~^data; mark = 1; space = 0.
  - perr_q = (sample != expected).
  - In mode none, perr_q=0.
- STOP: sample STOP_BITS bits at successive mid-bit points. ferr_q=1 if any stop sample is 0.
- Frame completion: completes in the clk cycle after the baud_tick that samples the last stop bit. On that cycle:
  - Break (data all zero, parity sample 0 if present, and any stop sample 0): break_detected=1 for one cycle, framing_error=1, parity_error=0, data_valid stays 0, received_data unchanged. Go to BREAK_WAIT.
  - Otherwise: received_data=data, parity_error=perr_q, framing_error=ferr_q, data_valid=1 for one cycle. Go to IDLE. A low line is then treated as a fresh start bit.
- BREAK_WAIT: stay until a baud_tick samples line=1, then go to IDLE. Exactly one break_detected pulse per break, regardless of its length.
- parity_err_count:
  - Increments by 1 on each completed frame with parity_error=1.
  - Saturates at all-ones.
  - clear_counts alone sets it to 0.
  - clear_counts coinciding with an increment yields 1.
- is_parity_stage is combinational from the state register; no other output is combinational.

Test Plan (OVERSAMPLE=16, INPUT_DATA_WIDTH=8, STOP_BITS=1 unless stated):
- Even mode, frame 0xA5, parity bit 0, stop 1 -> received_data=0xA5, data_valid pulses once, 1 clk after the stop-bit mid-sample; parity_error=0, framing_error=0.
- Odd mode, same 0xA5 frame with parity bit 0 -> parity_error=1; parity_err_count 0 -> 1. Repeat with clear_counts asserted on the completion cycle -> count = 1. With ERR_CNT_WIDTH=2, 5 bad frames -> count saturates at 3.
- Line low for 4 baud_ticks, then high -> START aborts; no data_valid; state back to IDLE.
- Mode none, frame 0x3C with stop bit 0 -> data_valid=1, received_data=0x3C, framing_error=1, parity_error=0. Mark mode with parity bit 0 -> parity_error=1.
- Line held low for 30 bit times, then high -> one break_detected pulse, framing_error=1, no data_valid. The next frame 0x5A is received correctly.
- Reset driven low during data bit 4 of a frame -> all outputs 0 immediately. After release, frame 0x81 with STOP_BITS=2 and second stop bit 0 -> framing_error=1, received_data=0x81.

Source files
------------

// File: rtl/uart_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_checker
// Description : UART receive-frame engine with start detection, mid-bit
//               sampling, runtime parity mode, stop check and break detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_checker #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int OVERSAMPLE       = 16,
  parameter int STOP_BITS        = 1,
  parameter int ERR_CNT_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in_synced,
  input  logic                        baud_tick,
  input  logic [2:0]                  parity_mode,
  input  logic                        clear_counts,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_valid,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        break_detected,
  output logic                        is_parity_stage,
  output logic [ERR_CNT_WIDTH-1:0]    parity_err_count
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(INPUT_DATA_WIDTH);
  localparam logic [TICK_W-1:0] c_HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] c_FULL_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  c_LAST_DATA = IDX_W'(INPUT_DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  c_LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_BREAK_WAIT = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [TICK_W-1:0]           r_tick;
  logic [IDX_W-1:0]            r_bit_idx;
  logic [INPUT_DATA_WIDTH-1:0] r_shift;
  logic [2:0]                  r_mode;
  logic                        r_perr;
  logic                        r_ferr;
  logic                        r_par_bit;
  logic                        w_mid;
  logic                        w_has_parity;
  logic                        w_expected_par;
  logic                        w_stop_low_any;
  logic                        w_is_break;
  logic                        w_last_stop;

  // Start bit is sampled at its half-point; every later bit one full period on.
  always_comb begin
    w_mid = 1'b0;
    if (baud_tick) begin
      if (r_state == S_START) w_mid = (r_tick == c_HALF_TICK);
      else                    w_mid = (r_tick == c_FULL_TICK);
    end
  end

  assign w_has_parity   = (r_mode >= 3'd1) && (r_mode <= 3'd4);
  assign w_stop_low_any = r_ferr | ~serial_in_synced;
  assign w_is_break     = (r_shift == '0) & ~r_par_bit & w_stop_low_any;
  assign w_last_stop    = (r_state == S_STOP) & w_mid & (r_bit_idx == c_LAST_STOP);
  assign is_parity_stage = (r_state == S_PARITY);

  always_comb begin
    case (r_mode)
      3'd1:    w_expected_par = ^r_shift;
      3'd2:    w_expected_par = ~^r_shift;
      3'd3:    w_expected_par = 1'b1;
      default: w_expected_par = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (baud_tick && !serial_in_synced) w_next_state = S_START;
      S_START:      if (w_mid) w_next_state = serial_in_synced ? S_IDLE : S_DATA;
      S_DATA:       if (w_mid && (r_bit_idx == c_LAST_DATA))
                      w_next_state = w_has_parity ? S_PARITY : S_STOP;
      S_PARITY:     if (w_mid) w_next_state = S_STOP;
      S_STOP:       if (w_last_stop) w_next_state = w_is_break ? S_BREAK_WAIT : S_IDLE;
      S_BREAK_WAIT: if (baud_tick && serial_in_synced) w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick           <= '0;
      r_bit_idx        <= '0;
      r_shift          <= '0;
      r_mode           <= '0;
      r_perr           <= 1'b0;
      r_ferr           <= 1'b0;
      r_par_bit        <= 1'b0;
      received_data    <= '0;
      data_valid       <= 1'b0;
      parity_error     <= 1'b0;
      framing_error    <= 1'b0;
      break_detected   <= 1'b0;
      parity_err_count <= '0;
    end else begin
      data_valid     <= 1'b0;
      break_detected <= 1'b0;
      case (r_state)
        S_IDLE: if (baud_tick && !serial_in_synced) begin
          r_mode <= parity_mode;
          r_tick <= '0;
        end
        S_START, S_DATA, S_PARITY, S_STOP: if (baud_tick) begin
          r_tick <= w_mid ? '0 : r_tick + 1'b1;
        end
        default: ;
      endcase
      if (w_mid) begin
        case (r_state)
          S_START: begin
            r_bit_idx <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_par_bit <= 1'b0;
          end
          S_DATA: begin
            r_shift   <= {serial_in_synced, r_shift[INPUT_DATA_WIDTH-1:1]};
            r_bit_idx <= (r_bit_idx == c_LAST_DATA) ? '0 : r_bit_idx + 1'b1;
          end
          S_PARITY: begin
            r_par_bit <= serial_in_synced;
            r_perr    <= (serial_in_synced != w_expected_par);
          end
          S_STOP: begin
            if (!serial_in_synced) r_ferr <= 1'b1;
            r_bit_idx <= r_bit_idx + 1'b1;
          end
          default: ;
        endcase
      end
      // Frame completion: results become visible the cycle after the last stop sample.
      if (w_last_stop) begin
        if (w_is_break) begin
          break_detected <= 1'b1;
          framing_error  <= 1'b1;
          parity_error   <= 1'b0;
        end else begin
          received_data  <= r_shift;
          parity_error   <= r_perr;
          framing_error  <= w_stop_low_any;
          data_valid     <= 1'b1;
        end
      end
      // Counter follows the visible status, so a clear on the completion cycle leaves 1.
      if (clear_counts)
        parity_err_count <= (data_valid && parity_error) ? ERR_CNT_WIDTH'(1) : '0;
      else if (data_valid && parity_error && (parity_err_count != '1))
        parity_err_count <= parity_err_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_checker
// Description : Scoreboard bench for uart_rx_frame_checker (random + directed frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_checker;

  localparam int DW   = 8;
  localparam int OS   = 16;
  localparam int SB   = 2;
  localparam int ERRW = 3;
  localparam int TDIV = 2;

  typedef struct {
    bit            brk;
    logic [DW-1:0] data;
    bit            perr;
    bit            ferr;
    bit            haspar;
    logic [ERRW-1:0] cnt;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            serial_in_synced;
  logic            baud_tick;
  logic [2:0]      parity_mode;
  logic            clear_counts;
  logic            clr_pulse;
  logic            clr_auto;
  logic [DW-1:0]   received_data;
  logic            data_valid;
  logic            parity_error;
  logic            framing_error;
  logic            break_detected;
  logic            is_parity_stage;
  logic [ERRW-1:0] parity_err_count;

  exp_t            expq[$];
  int              vectors;
  int              miscompares;
  logic [DW-1:0]   last_data;
  logic [ERRW-1:0] model_cnt;
  bit              clr_arm;
  bit              par_seen;
  bit              cnt_pending;
  logic [ERRW-1:0] cnt_expected;

  assign clear_counts = clr_pulse | clr_auto;

  uart_rx_frame_checker #(
    .INPUT_DATA_WIDTH(DW), .OVERSAMPLE(OS), .STOP_BITS(SB), .ERR_CNT_WIDTH(ERRW)
  ) dut (
    .clk(clk), .reset(reset), .serial_in_synced(serial_in_synced), .baud_tick(baud_tick),
    .parity_mode(parity_mode), .clear_counts(clear_counts), .received_data(received_data),
    .data_valid(data_valid), .parity_error(parity_error), .framing_error(framing_error),
    .break_detected(break_detected), .is_parity_stage(is_parity_stage),
    .parity_err_count(parity_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = ~baud_tick;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: frame contents -> expected frame result and counter value.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [2:0] mode, input logic pbit,
                                 input logic [1:0] stops, input bit clr);
    exp_t e;
    bit   exp_p;
    bit   any0;
    e.haspar = (mode >= 3'd1) && (mode <= 3'd4);
    case (mode)
      3'd1:    exp_p = ^d;
      3'd2:    exp_p = ~^d;
      3'd3:    exp_p = 1'b1;
      default: exp_p = 1'b0;
    endcase
    any0 = 1'b0;
    for (int i = 0; i < SB; i++) if (!stops[i]) any0 = 1'b1;
    e.brk = (d == '0) && (!e.haspar || !pbit) && any0;
    if (e.brk) begin
      e.data = last_data;
      e.perr = 1'b0;
      e.ferr = 1'b1;
    end else begin
      e.data = d;
      e.perr = e.haspar && (pbit != exp_p);
      e.ferr = any0;
      last_data = d;
    end
    if (clr) model_cnt = (!e.brk && e.perr) ? ERRW'(1) : '0;
    else if (!e.brk && e.perr && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    e.cnt = model_cnt;
    return e;
  endfunction

  task automatic send_bit(input logic b);
    serial_in_synced = b;
    repeat (OS * TDIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic [2:0] mode, input logic pbit,
                            input logic [1:0] stops, input bit clr, input bit chg_mode);
    exp_t e;
    e = model(d, mode, pbit, stops, clr);
    if (clr) clr_arm = 1'b1;
    expq.push_back(e);
    parity_mode = mode;
    send_bit(1'b0);
    if (chg_mode) parity_mode = 3'($urandom_range(0, 7));
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (e.haspar) send_bit(pbit);
    for (int i = 0; i < SB; i++) send_bit(stops[i]);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // Asserts clear_counts on the completion cycle of the armed frame.
  initial begin
    clr_auto = 1'b0;
    forever begin
      @(negedge clk);
      clr_auto = 1'b0;
      if (clr_arm && data_valid) begin
        clr_auto = 1'b1;
        clr_arm  = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports a frame.
  initial begin
    exp_t e;
    par_seen    = 1'b0;
    cnt_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        par_seen    = 1'b0;
        cnt_pending = 1'b0;
      end else begin
        if (cnt_pending) begin
          chk("err_count", 32'(parity_err_count), 32'(cnt_expected));
          cnt_pending = 1'b0;
        end
        if (is_parity_stage) par_seen = 1'b1;
        if (data_valid || break_detected) begin
          if (expq.size() == 0) begin
            chk("unexpected_output", {30'd0, break_detected, data_valid}, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("break_detected", 32'(break_detected), 32'(e.brk));
            chk("data_valid", 32'(data_valid), 32'(!e.brk));
            chk("received_data", 32'(received_data), 32'(e.data));
            chk("parity_error", 32'(parity_error), 32'(e.perr));
            chk("framing_error", 32'(framing_error), 32'(e.ferr));
            chk("parity_stage_seen", 32'(par_seen), 32'(e.haspar));
            cnt_expected = e.cnt;
            cnt_pending  = 1'b1;
          end
          par_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic [DW-1:0] d;
    logic [1:0]    st;
    vectors          = 0;
    miscompares      = 0;
    last_data        = '0;
    model_cnt        = '0;
    clr_arm          = 1'b0;
    clr_pulse        = 1'b0;
    reset            = 1'b0;
    serial_in_synced = 1'b1;
    parity_mode      = 3'd0;
    repeat (4) @(negedge clk);
    chk("rst_received_data", 32'(received_data), 32'd0);
    chk("rst_flags", {26'd0, data_valid, parity_error, framing_error, break_detected, is_parity_stage, 1'b0}, 32'd0);
    chk("rst_err_count", 32'(parity_err_count), 32'd0);
    reset = 1'b1;
    send_bit(1'b1);

    send_frame(8'hA5, 3'd1, 1'b0, 2'b11, 1'b0, 1'b0);   // even, good
    send_frame(8'hA5, 3'd2, 1'b0, 2'b11, 1'b0, 1'b0);   // odd, bad -> count 1
    send_frame(8'hA5, 3'd2, 1'b0, 2'b11, 1'b1, 1'b0);   // clear on completion -> 1
    @(negedge clk); clr_pulse = 1'b1;
    @(negedge clk); clr_pulse = 1'b0;
    model_cnt = '0;

    serial_in_synced = 1'b0;                             // glitch start
    repeat (4 * TDIV) @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);

    send_frame(8'h3C, 3'd0, 1'b0, 2'b10, 1'b0, 1'b0);   // none, stop low
    send_frame(8'h11, 3'd3, 1'b0, 2'b11, 1'b0, 1'b0);   // mark, bad parity

    e = model('0, 3'd0, 1'b0, 2'b00, 1'b0);              // long break
    expq.push_back(e);
    parity_mode = 3'd0;
    repeat (30) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h5A, 3'd1, 1'b0, 2'b11, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) send_frame(8'hA5, 3'd2, 1'b0, 2'b11, 1'b0, 1'b0); // saturate

    parity_mode = 3'd0;                                  // reset mid data bit 4
    d = 8'h3F;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    serial_in_synced = d[4];
    repeat (OS * TDIV / 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_received_data", 32'(received_data), 32'd0);
    chk("abort_flags", {26'd0, data_valid, parity_error, framing_error, break_detected, is_parity_stage, 1'b0}, 32'd0);
    chk("abort_err_count", 32'(parity_err_count), 32'd0);
    last_data = '0;
    model_cnt = '0;
    @(negedge clk);
    serial_in_synced = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    send_bit(1'b1);
    send_frame(8'h81, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0);   // second stop low

    for (int n = 0; n < 24; n++) begin
      d = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
      for (int i = 0; i < SB; i++) st[i] = ($urandom_range(0, 4) != 0);
      send_frame(d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), st, 1'b0,
                 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 2000 && expq.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
